// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between
// requester A (ALU writeback) and requester B (load writeback), and keeps a
// per-register busy scoreboard used by the decoder for RAW/WAW stalls.
//
// Configuration macro: RFARB_FIXED_PRIO_EN
//   undefined (default): round-robin between A and B, A favoured after reset
//   defined            : B has strict priority whenever both are valid
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   rsv_valid, rsv_reg            decoder reservation of a destination register
//   chk_src1, chk_src2, chk_dst   registers of the instruction in decode
//   hazard                        combinational stall request
//   a_valid/a_reg/a_data/a_ready  requester A write handshake (ready is comb)
//   b_valid/b_reg/b_data/b_ready  requester B write handshake (ready is comb)
//   rf_WriteReg/rf_DstReg/rf_DstData  registered register-file write port
//   busy_vec                      scoreboard, bit r = write outstanding to r
module rf_write_arbiter #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_reg,
  input  logic [ADDR_W-1:0]   chk_src1,
  input  logic [ADDR_W-1:0]   chk_src2,
  input  logic [ADDR_W-1:0]   chk_dst,
  output logic                hazard,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  output logic                rf_WriteReg,
  output logic [ADDR_W-1:0]   rf_DstReg,
  output logic [DATA_W-1:0]   rf_DstData,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic                grant_a;
  logic                grant_b;
  logic                xfer;
  logic [ADDR_W-1:0]   xfer_reg;

  logic                wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0]   dst_reg_q,  dst_reg_d;
  logic [DATA_W-1:0]   dst_data_q, dst_data_d;
  logic [NUM_REGS-1:0] busy_q,     busy_d;

`ifdef RFARB_FIXED_PRIO_EN
  // Fixed priority: B wins every contention; no pointer state exists.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      grant_b = b_valid;
      grant_a = a_valid && !b_valid;
    end
  end
`else
  typedef enum logic {
    FAV_A = 1'b0,
    FAV_B = 1'b1
  } rr_state_e;

  rr_state_e ptr_q, ptr_d;

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= FAV_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grant selection and pointer advance; grants are suppressed during reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    ptr_d   = ptr_q;
    if (rst_n) begin
      if (a_valid && b_valid) begin
        if (ptr_q == FAV_B) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    if (grant_a) begin
      ptr_d = FAV_B;
    end else if (grant_b) begin
      ptr_d = FAV_A;
    end
  end
`endif

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign xfer     = grant_a || grant_b;
  assign xfer_reg = grant_a ? a_reg : b_reg;

  // Write port next state: load on transfer, R0 writes never enable the RF.
  always_comb begin
    wr_en_d    = 1'b0;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    if (grant_a) begin
      dst_reg_d  = a_reg;
      dst_data_d = a_data;
      wr_en_d    = (a_reg != '0);
    end else if (grant_b) begin
      dst_reg_d  = b_reg;
      dst_data_d = b_data;
      wr_en_d    = (b_reg != '0);
    end
  end

  // Scoreboard next state: clear on completing transfer, then set so a
  // younger reservation of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer) begin
      busy_d[xfer_reg] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[rsv_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any write in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
      busy_q     <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
      busy_q     <= busy_d;
    end
  end

  // busy_q[0] is always zero, so R0 never raises a hazard.
  assign hazard      = busy_q[chk_src1] | busy_q[chk_src2] | busy_q[chk_dst];

  assign rf_WriteReg = wr_en_q;
  assign rf_DstReg   = dst_reg_q;
  assign rf_DstData  = dst_data_q;
  assign busy_vec    = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed stimulus, expected register-file
// writes queued by the driver and checked by an independent monitor.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rsv_valid;
  logic [3:0]  rsv_reg;
  logic [3:0]  chk_src1;
  logic [3:0]  chk_src2;
  logic [3:0]  chk_dst;
  logic        hazard;
  logic        a_valid;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        b_ready;
  logic        rf_WriteReg;
  logic [3:0]  rf_DstReg;
  logic [15:0] rf_DstData;
  logic [15:0] busy_vec;

  typedef struct packed {
    logic        src_b;
    logic        we;
    logic [3:0]  r;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rf_write_arbiter #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rsv_valid   (rsv_valid),
    .rsv_reg     (rsv_reg),
    .chk_src1    (chk_src1),
    .chk_src2    (chk_src2),
    .chk_dst     (chk_dst),
    .hazard      (hazard),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .rf_WriteReg (rf_WriteReg),
    .rf_DstReg   (rf_DstReg),
    .rf_DstData  (rf_DstData),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic src_b, input logic [3:0] r, input logic [15:0] d);
    exp_t e;
    e.src_b = src_b;
    e.we    = (r != 4'd0);
    e.r     = r;
    e.d     = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    rsv_valid = 1'b0; rsv_reg = 4'd0;
    chk_src1 = 4'd0; chk_src2 = 4'd0; chk_dst = 4'd0;
    a_valid = 1'b0; a_reg = 4'd0; a_data = 16'h0;
    b_valid = 1'b0; b_reg = 4'd0; b_data = 16'h0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted transfer must match the next queued write.
  always @(posedge clk) begin
    logic xa;
    logic xb;
    exp_t e;
    xa = a_valid && a_ready;
    xb = b_valid && b_ready;
    if (xa || xb) begin
      #1;
      if (xa && xb) begin
        n_checks++;
        n_fail++;
        $display("FAIL dual_grant: got both A and B accepted, required one at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_xfer: got transfer reg=%0d, required none at %0t", rf_DstReg, $time);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_src_b",   32'(xb),          32'(e.src_b));
        chk("rf_WriteReg",  32'(rf_WriteReg), 32'(e.we));
        chk("rf_DstReg",    32'(rf_DstReg),   32'(e.r));
        chk("rf_DstData",   32'(rf_DstData),  32'(e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n   = 1'b0;
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1111;
    b_valid = 1'b1; b_reg = 4'd6; b_data = 16'h2222;

    // Reset held two cycles with both requesters valid.
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_a_ready",     32'(a_ready),     32'd0);
      chk("rst_b_ready",     32'(b_ready),     32'd0);
      chk("rst_WriteReg",    32'(rf_WriteReg), 32'd0);
      chk("rst_DstReg",      32'(rf_DstReg),   32'd0);
      chk("rst_DstData",     32'(rf_DstData),  32'h0);
      chk("rst_busy",        32'(busy_vec),    32'h0);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Single write from A.
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h03FE;
    push(1'b0, 4'd2, 16'h03FE);
    #1;
    chk("single_a_ready", 32'(a_ready), 32'd1);
    chk("single_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("single_wr_drop", 32'(rf_WriteReg), 32'd0);
    chk("single_reg_hold", 32'(rf_DstReg),  32'd2);

    // Contention from reset: both held three cycles.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_reg = 4'd13; a_data = 16'hDDDD;
      b_valid = 1'b1; b_reg = 4'd5;  b_data = 16'h1234;
`ifdef RFARB_FIXED_PRIO_EN
      push(1'b1, 4'd5, 16'h1234);
      #1;
      chk("cont_a_ready", 32'(a_ready), 32'd0);
      chk("cont_b_ready", 32'(b_ready), 32'd1);
`else
      if (i == 1) push(1'b1, 4'd5, 16'h1234);
      else        push(1'b0, 4'd13, 16'hDDDD);
      #1;
      chk("cont_a_ready", 32'(a_ready), (i == 1) ? 32'd0 : 32'd1);
      chk("cont_b_ready", 32'(b_ready), (i == 1) ? 32'd1 : 32'd0);
`endif
    end
    @(negedge clk);
    idle_inputs();

    // Scoreboard reserve, hazard, then clear by a B write.
    @(negedge clk);
    rsv_valid = 1'b1; rsv_reg = 4'd7;
    @(negedge clk);
    rsv_valid = 1'b0; chk_src1 = 4'd7;
    #1;
    chk("sb_hazard_set", 32'(hazard),   32'd1);
    chk("sb_busy_set",   32'(busy_vec), 32'h0080);
    @(negedge clk);
    b_valid = 1'b1; b_reg = 4'd7; b_data = 16'hBEEF;
    push(1'b1, 4'd7, 16'hBEEF);
    #1;
    chk("sb_b_ready",       32'(b_ready), 32'd1);
    chk("sb_hazard_xfer",   32'(hazard),  32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk("sb_hazard_clear",  32'(hazard),   32'd0);
    chk("sb_busy_clear",    32'(busy_vec), 32'h0);
    idle_inputs();

    // Set and clear of reg 4 on the same edge: set wins.
    @(negedge clk);
    rsv_valid = 1'b1; rsv_reg = 4'd4;
    @(negedge clk);
    rsv_valid = 1'b1; rsv_reg = 4'd4; chk_dst = 4'd4;
    a_valid = 1'b1; a_reg = 4'd4; a_data = 16'h4444;
    push(1'b0, 4'd4, 16'h4444);
    #1;
    chk("col_busy_pre",  32'(busy_vec), 32'h0010);
    chk("col_hazard",    32'(hazard),   32'd1);
    chk("col_a_ready",   32'(a_ready),  32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("col_busy_kept", 32'(busy_vec), 32'h0010);
    @(negedge clk);
    b_valid = 1'b1; b_reg = 4'd4; b_data = 16'h0404;
    push(1'b1, 4'd4, 16'h0404);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk("col_busy_clr",  32'(busy_vec), 32'h0);

    // R0 write is accepted but never enables the register file.
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd0; a_data = 16'hFFFF;
    push(1'b0, 4'd0, 16'hFFFF);
    #1;
    chk("r0_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_reg = 4'd0;
    @(negedge clk);
    rsv_valid = 1'b0;
    #1;
    chk("r0_busy",   32'(busy_vec),    32'h0);
    chk("r0_hazard", 32'(hazard),      32'd0);
    chk("r0_wr_low", 32'(rf_WriteReg), 32'd0);

    // Reset asserted the cycle after a transfer to reg 9.
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h0909;
    rsv_valid = 1'b1; rsv_reg = 4'd3;
    push(1'b0, 4'd9, 16'h0909);
    #1;
    chk("mid_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    rsv_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_ready", 32'(a_ready),  32'd0);
    chk("mid_busy_pre",    32'(busy_vec), 32'h0008);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b0;
    #1;
    chk("mid_wr_drop",  32'(rf_WriteReg), 32'd0);
    chk("mid_busy_rst", 32'(busy_vec),    32'h0);
    chk("mid_reg_rst",  32'(rf_DstReg),   32'd0);
    chk("mid_data_rst", 32'(rf_DstData),  32'h0);

    @(negedge clk);
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU writeback) and B (memory/load writeback).
- Keeps a per-register busy scoreboard that the decoder uses to stall on RAW/WAW hazards.
- Sits between the writeback stage and the RegisterFile write inputs (WriteReg / DstReg / DstData).
- The read ports of the register file are not touched by this block.

Parameters:
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, 4, register index width (log2 NUM_REGS).
- DATA_W, 16, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- rsv_valid  input  1  decoder issues an instruction that will write rsv_reg.
- rsv_reg  input  ADDR_W  destination register being reserved.
- chk_src1  input  ADDR_W  source register 1 of the instruction in decode.
- chk_src2  input  ADDR_W  source register 2 of the instruction in decode.
- chk_dst  input  ADDR_W  destination register of the instruction in decode.
- hazard  output  1  combinational stall request to the decoder.
- a_valid  input  1  requester A has a write.
- a_reg  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- a_ready  output  1  requester A write accepted this cycle.
- b_valid  input  1  requester B has a write.
- b_reg  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- b_ready  output  1  requester B write accepted this cycle.
- rf_WriteReg  output  1  register file write enable (registered).
- rf_DstReg  output  ADDR_W  register file write index (registered).
- rf_DstData  output  DATA_W  register file write data (registered).
- busy_vec  output  NUM_REGS  scoreboard state, bit r = register r has a write outstanding.

Behaviour:
- Reset: while rst_n=0 at a rising edge:
  - busy_vec=0, rf_WriteReg=0, rf_DstReg=0, rf_DstData=0.
  - Round-robin pointer is set to favour A.
  - a_ready=0 and b_ready=0 for the whole cycle in which rst_n is low.
  - A write in flight when reset asserts is dropped and never reaches the register file.
- Arbitration (combinational, one grant per cycle):
  - Only one valid: that requester is granted.
  - Both valid: the pointer decides.
  - After a grant the pointer moves to favour the other requester; with no grant it holds.
- Handshake:
  - a_ready = grant_A and b_ready = grant_B. A ready never rises without its valid.
  - A transfer occurs when valid and ready are both high.
  - A requester that is not granted must hold valid, reg and data stable until it is granted.
- Write port latency is 1 cycle. On the edge that completes a transfer, the registers load:
  - rf_DstReg <= granted reg
  - rf_DstData <= granted data
  - rf_WriteReg <= 1 if reg != 0, else 0
- With no transfer, rf_WriteReg <= 0 and rf_DstReg / rf_DstData hold their values.
- R0 is hardwired to zero:
  - A write to R0 is accepted (ready=1) but never drives rf_WriteReg.
  - busy_vec[0] is never set.
- Scoreboard, updated at each rising edge:
  - Set: busy[rsv_reg] <= 1 when rsv_valid=1 and rsv_reg != 0.
  - Clear: busy[r] <= 0 when a transfer to r completes.
  - Set and clear of the same register on the same edge: set wins, because the new reservation belongs to a younger instruction.
  - Re-reserving a register that is already busy leaves it busy (single bit, no count). The hazard check on chk_dst prevents this in normal operation.
- Hazard (combinational):
  - hazard = busy[chk_src1] | busy[chk_src2] | busy[chk_dst].
  - Index 0 never contributes.
  - A transfer completing in the current cycle does not lower hazard until the next cycle.
- Same destination from A and B in one cycle: the loser waits. The two writes land in grant order on consecutive cycles.

Optional Feature:
- Macro: RFARB_FIXED_PRIO_EN.
- Defined: B has strict priority over A whenever both are valid. The pointer is not implemented and A can starve.
- Undefined (default): round-robin arbitration as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_WriteReg=0, rf_DstReg=0, rf_DstData=0, busy_vec=16'h0000.
- Single write: after reset, a_valid=1, a_reg=2, a_data=16'h03FE for 1 cycle -> a_ready=1 that cycle; next cycle rf_WriteReg=1, rf_DstReg=2, rf_DstData=16'h03FE; the following cycle rf_WriteReg=0.
- Contention: A(reg 13, 16'hDDDD) and B(reg 5, 16'h1234) both valid and held for 3 cycles from reset -> grants A, B, A on successive cycles; rf_DstReg sequence 13, 5, 13. With RFARB_FIXED_PRIO_EN defined -> B granted every cycle and a_ready stays 0.
- Scoreboard: rsv_valid=1, rsv_reg=7; next cycle chk_src1=7 -> hazard=1, busy_vec=16'h0080. Write B(reg 7, 16'hBEEF) -> hazard=1 in the transfer cycle, hazard=0 the cycle after, busy_vec=0.
- Set/clear collision: busy[4]=1; in one cycle rsv_valid=1, rsv_reg=4 and A transfers to reg 4 -> busy[4] stays 1 and rf_WriteReg=1 next cycle.
- R0 and mid-operation reset:
  - A write to R0 (16'hFFFF) -> a_ready=1, rf_WriteReg stays 0.
  - rsv_reg=0 -> busy_vec unchanged.
  - Assert rst_n=0 in the cycle after a transfer to reg 9 -> rf_WriteReg=0 and busy_vec=0 at the next edge.
